// File: rtl/ram8_block_mover.sv
// ram8_block_mover: bus initiator for an 8-word RAM port (address/load/in/out).
// Runs one command at a time: copies len_m1_i+1 words from src_i to dst_i
// (one read cycle then one write cycle per word, ascending), or fills
// len_m1_i+1 words starting at dst_i with fill_val_i (one write per cycle).
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   start_i              command strobe, accepted only while idle
//   fill_i               0 = copy, 1 = fill
//   src_i, dst_i         base addresses (modulo 2**ADDR_W)
//   len_m1_i             word count minus one
//   fill_val_i           fill constant
//   mem_out_i            RAM combinational read data for mem_addr_o
//   mem_addr_o/mem_in_o  RAM address / write data
//   mem_load_o           RAM write enable
//   busy_o               high while a command executes
//   done_o               one-cycle pulse after the last write
module ram8_block_mover #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] len_m1_i,
  input  logic [WIDTH-1:0]  fill_val_i,
  input  logic [WIDTH-1:0]  mem_out_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WIDTH-1:0]  mem_in_o,
  output logic              mem_load_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [WIDTH-1:0]  val_q, val_d;
  logic              fill_q, fill_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_in_q, mem_in_d;
  logic              mem_load_q, mem_load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next state, index and command latch; outputs are decoded from the next
  // values so the registered bus lines lead the state by no cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    val_d   = val_q;
    fill_d  = fill_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d   = src_i;
          dst_d   = dst_i;
          len_d   = len_m1_i;
          val_d   = fill_val_i;
          fill_d  = fill_i;
          idx_d   = '0;
          state_d = fill_i ? S_FILL : S_READ;
        end
      end
      S_READ: begin
        hold_d  = mem_out_i;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == len_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_FILL: begin
        if (idx_q == len_q) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_addr_d = '0;
    mem_in_d   = '0;
    mem_load_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_d)
      S_READ: begin
        mem_addr_d = src_d + idx_d;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        mem_addr_d = dst_d + idx_d;
        mem_in_d   = hold_d;
        mem_load_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_FILL: begin
        mem_addr_d = dst_d + idx_d;
        mem_in_d   = val_d;
        mem_load_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      val_q      <= '0;
      fill_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      mem_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      val_q      <= val_d;
      fill_q     <= fill_d;
      mem_addr_q <= mem_addr_d;
      mem_in_q   <= mem_in_d;
      mem_load_q <= mem_load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_in_o   = mem_in_q;
  assign mem_load_o = mem_load_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_ram8_block_mover.sv
// Testbench for ram8_block_mover: an 8-word RAM model attached to the bus,
// directed scenarios plus random commands, each checked against an
// array-level model of what the command should do to memory.
module tb_ram8_block_mover;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        fill_i;
  logic [2:0]  src_i, dst_i, len_m1_i;
  logic [15:0] fill_val_i;
  logic [15:0] mem_out;
  logic [2:0]  mem_addr;
  logic [15:0] mem_in;
  logic        mem_load;
  logic        busy, done;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [15:0] ram[8];
  logic [15:0] mram[8];
  logic [15:0] pre_img[8];
  logic        pre_we = 1'b0;
  wr_t         wr_q[$];
  wr_t         exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram8_block_mover #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .fill_i(fill_i),
    .src_i(src_i), .dst_i(dst_i), .len_m1_i(len_m1_i), .fill_val_i(fill_val_i),
    .mem_out_i(mem_out), .mem_addr_o(mem_addr), .mem_in_o(mem_in),
    .mem_load_o(mem_load), .busy_o(busy), .done_o(done)
  );

  // RAM: combinational read, write at the rising edge; every write is logged.
  assign mem_out = ram[mem_addr];
  always @(posedge clk) begin
    if (pre_we) begin
      ram <= pre_img;
    end else if (mem_load) begin
      ram[mem_addr] <= mem_in;
      wr_q.push_back('{a: mem_addr, d: mem_in});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    @(negedge clk);
    pre_we = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
    for (int i = 0; i < 8; i++) mram[i] = pre_img[i];
  endtask

  task automatic preload_random();
    for (int i = 0; i < 8; i++) pre_img[i] = 16'($urandom);
    preload();
  endtask

  // Model: each word in ascending order takes the source word as it stands
  // at that moment, so overlapping copies propagate earlier writes.
  task automatic model_cmd(input logic f, input logic [2:0] s, input logic [2:0] d,
                           input int nwords, input logic [15:0] v);
    exp_q.delete();
    for (int k = 0; k < nwords; k++) begin
      logic [2:0]  wa;
      logic [2:0]  ra;
      logic [15:0] wd;
      wa = 3'((int'(d) + k) % 8);
      ra = 3'((int'(s) + k) % 8);
      wd = f ? v : mram[ra];
      mram[wa] = wd;
      exp_q.push_back('{a: wa, d: wd});
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      wr_t got;
      got = (k < wr_q.size()) ? wr_q[k] : 'x;
      chk({tag, "_wr"}, 32'(got), 32'(exp_q[k]));
    end
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 8; i++) chk({tag, "_ram"}, 32'(ram[i]), 32'(mram[i]));
  endtask

  // Launch one command and follow it to idle; poke pulses a stray start
  // (with a different fill value) mid-command and in the done cycle.
  task automatic run_cmd(input string tag, input logic f, input logic [2:0] s,
                         input logic [2:0] d, input logic [2:0] l,
                         input logic [15:0] v, input bit poke);
    int n;
    int nwords;
    nwords = int'(l) + 1;
    model_cmd(f, s, d, nwords, v);
    @(negedge clk);
    wr_q.delete();
    fill_i = f; src_i = s; dst_i = d; len_m1_i = l; fill_val_i = v;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      chk({tag, "_done_in_busy"}, 32'(done), 32'd0);
      if (poke && n == 3) begin
        start_i = 1'b1;
        fill_val_i = 16'hB123;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), f ? 32'(nwords) : 32'(2 * nwords));
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    chk({tag, "_done_load"}, 32'(mem_load), 32'd0);
    if (poke) begin
      start_i = 1'b1;
      fill_val_i = 16'hB123;
    end
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_load"}, 32'(mem_load), 32'd0);
    check_writes(tag);
    check_ram(tag);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; fill_i = 1'b0;
    src_i = '0; dst_i = '0; len_m1_i = '0; fill_val_i = '0;
    for (int i = 0; i < 8; i++) pre_img[i] = 16'h0;
    pre_we = 1'b1;
    repeat (2) @(posedge clk);
    #1 pre_we = 1'b0;
    for (int i = 0; i < 8; i++) mram[i] = 16'h0;
    @(negedge clk);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_in", 32'(mem_in), 32'd0);
    chk("rst_load", 32'(mem_load), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_i = 1'b0;

    // Single-word fill
    run_cmd("fill1", 1'b1, 3'd0, 3'd0, 3'd0, 16'h1234, 1'b0);

    // Copy with a zero word in the middle
    for (int i = 0; i < 8; i++) pre_img[i] = 16'h0;
    pre_img[5] = 16'h1424;
    pre_img[7] = 16'hAAAA;
    preload();
    run_cmd("copy", 1'b0, 3'd5, 3'd1, 3'd2, 16'h0, 1'b0);

    // Fill wrapping past address 7
    run_cmd("wrap", 1'b1, 3'd0, 3'd6, 3'd3, 16'hFFFF, 1'b0);

    // Overlapping copy smears word 0 upward
    for (int i = 0; i < 8; i++) pre_img[i] = 16'h0;
    for (int i = 0; i < 4; i++) pre_img[i] = 16'(i + 1);
    preload();
    run_cmd("overlap", 1'b0, 3'd0, 3'd1, 3'd2, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) chk("overlap_abs", 32'(ram[i]), 32'h0001);

    // Stray starts are ignored; the next idle start is taken
    run_cmd("busy_start", 1'b1, 3'd0, 3'd2, 3'd7, 16'h5A5A, 1'b1);
    for (int k = 0; k < wr_q.size(); k++)
      chk("busy_start_nob123", 32'(wr_q[k].d == 16'hB123), 32'd0);
    run_cmd("after_busy", 1'b1, 3'd0, 3'd3, 3'd1, 16'h0F0F, 1'b0);

    // Reset in the second write of a 4-word copy
    begin
      preload_random();
      model_cmd(1'b0, 3'd4, 3'd0, 2, 16'h0);
      @(negedge clk);
      wr_q.delete();
      fill_i = 1'b0; src_i = 3'd4; dst_i = 3'd0; len_m1_i = 3'd3;
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_in_write", 32'(mem_load), 32'd1);
      reset_i = 1'b1;
      @(posedge clk);
      #1 reset_i = 1'b0;
      @(negedge clk);
      chk("rst_mid_load", 32'(mem_load), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_addr", 32'(mem_addr), 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_mid_still_idle", 32'(busy), 32'd0);
      check_writes("rst_mid");
      check_ram("rst_mid");
    end

    // Random commands
    for (int t = 0; t < 24; t++) begin
      if (t % 4 == 0) preload_random();
      run_cmd("rand", 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
              16'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
